// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- bundles the fetch-side enqueue packet, the decode-side
// dequeue lanes and the flush/stall controls of the fetch queue.
//
// Signals:
//   enq_valid, enq_ready       packet handshake (ready means room for a full packet)
//   enq_pc                     PC of slot 0
//   enq_instr, enq_predtarget  32 bits per slot, slot i at [32i+31:32i]
//   enq_mask, enq_predtaken    one bit per slot
//   redirect_valid             flush request
//   backend_stall              blocks dequeue
//   deq_ready                  consumer accepts every presented lane
//   deq_valid, deq_instr, deq_pc, deq_predtaken, deq_predtarget
//                              per-lane entry fields, lane 0 oldest
//   count, empty               occupancy
//
// Modports: master = producer/consumer side (testbench), slave = the queue.
interface fetch_queue_if #(
   parameter int FETCH_W = 4,
   parameter int DEQ_W   = 2,
   parameter int DEPTH   = 16,
   parameter int PC_W    = 64
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                    enq_valid;
   logic                    enq_ready;
   logic [PC_W-1:0]         enq_pc;
   logic [32*FETCH_W-1:0]   enq_instr;
   logic [FETCH_W-1:0]      enq_mask;
   logic [FETCH_W-1:0]      enq_predtaken;
   logic [32*FETCH_W-1:0]   enq_predtarget;

   logic                    redirect_valid;
   logic                    backend_stall;
   logic                    deq_ready;

   logic [DEQ_W-1:0]        deq_valid;
   logic [32*DEQ_W-1:0]     deq_instr;
   logic [PC_W*DEQ_W-1:0]   deq_pc;
   logic [DEQ_W-1:0]        deq_predtaken;
   logic [32*DEQ_W-1:0]     deq_predtarget;

   logic [CNT_W-1:0]        count;
   logic                    empty;

   modport master (
      output enq_valid, enq_pc, enq_instr, enq_mask, enq_predtaken, enq_predtarget,
      output redirect_valid, backend_stall, deq_ready,
      input  enq_ready, deq_valid, deq_instr, deq_pc, deq_predtaken, deq_predtarget,
      input  count, empty
   );

   modport slave (
      input  enq_valid, enq_pc, enq_instr, enq_mask, enq_predtaken, enq_predtarget,
      input  redirect_valid, backend_stall, deq_ready,
      output enq_ready, deq_valid, deq_instr, deq_pc, deq_predtaken, deq_predtarget,
      output count, empty
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- circular instruction buffer between fetch and decode.
// Accepts whole fetch packets (up to FETCH_W slots), compacts the surviving
// slots to the tail, and presents up to DEQ_W oldest entries per cycle.
// A redirect empties the queue; entry storage itself is never reset.
//
// Ports:
//   clock    rising-edge clock for all state
//   reset_n  asynchronous active-low reset of pointers and count
//   fq       fetch_queue_if slave modport (enqueue, dequeue, controls, occupancy)
module fetch_queue #(
   parameter int FETCH_W = 4,
   parameter int DEQ_W   = 2,
   parameter int DEPTH   = 16,
   parameter int PC_W    = 64
) (
   input  logic         clock,
   input  logic         reset_n,
   fetch_queue_if.slave fq
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      instr_mem  [DEPTH];
   logic [PC_W-1:0]  pc_mem     [DEPTH];
   logic [DEPTH-1:0] taken_mem;
   logic [31:0]      target_mem [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic [FETCH_W-1:0] keep;
   logic [PTR_W-1:0]   wr_idx [FETCH_W];
   logic [PTR_W-1:0]   rd_idx [DEQ_W];
   logic [CNT_W-1:0]   kept_cnt;
   logic [CNT_W-1:0]   n_enq;
   logic [CNT_W-1:0]   n_deq;
   logic               taken_seen;
   logic               enq_ready;
   logic               do_enq;
   logic               do_deq;

   // Slot filtering and compaction: a slot survives if it is valid and no
   // earlier valid slot was predicted taken. Each survivor is placed at the
   // tail plus the number of survivors before it, so writes are contiguous.
   always_comb begin
      keep       = '0;
      taken_seen = 1'b0;
      kept_cnt   = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         wr_idx[i] = tail + kept_cnt[PTR_W-1:0];
         if (fq.enq_mask[i] && !taken_seen) begin
            keep[i]  = 1'b1;
            kept_cnt = kept_cnt + CNT_W'(1);
            if (fq.enq_predtaken[i]) begin
               taken_seen = 1'b1;
            end
         end
      end
   end

   // Handshake decisions. Ready looks only at the registered count so that a
   // full packet always fits, even if the consumer stalls this cycle.
   always_comb begin
      enq_ready = (count <= CNT_W'(DEPTH - FETCH_W));
      do_enq    = fq.enq_valid && enq_ready && !fq.redirect_valid;
      do_deq    = fq.deq_ready && !fq.backend_stall && !fq.redirect_valid;
      n_enq     = do_enq ? kept_cnt : '0;
      n_deq     = '0;
      if (do_deq) begin
         n_deq = (count < CNT_W'(DEQ_W)) ? count : CNT_W'(DEQ_W);
      end
   end

   // Dequeue lanes read straight from storage; lane k shows entry head+k and
   // the pointer arithmetic wraps naturally at the power-of-two depth.
   always_comb begin
      fq.deq_valid      = '0;
      fq.deq_instr      = '0;
      fq.deq_pc         = '0;
      fq.deq_predtaken  = '0;
      fq.deq_predtarget = '0;
      for (int k = 0; k < DEQ_W; k++) begin
         rd_idx[k]                      = head + PTR_W'(k);
         fq.deq_valid[k]                = (count > CNT_W'(k)) && !fq.backend_stall && !fq.redirect_valid;
         fq.deq_instr[32*k +: 32]       = instr_mem[rd_idx[k]];
         fq.deq_pc[PC_W*k +: PC_W]      = pc_mem[rd_idx[k]];
         fq.deq_predtaken[k]            = taken_mem[rd_idx[k]];
         fq.deq_predtarget[32*k +: 32]  = target_mem[rd_idx[k]];
      end
      fq.enq_ready = enq_ready;
      fq.count     = count;
      fq.empty     = (count == '0);
   end

   // Entry storage; deliberately without reset since only the pointers define
   // which entries are live. Each slot PC is derived from the packet PC and
   // the slot's original index, not its compacted position.
   always_ff @(posedge clock) begin
      if (do_enq) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (keep[i]) begin
               instr_mem[wr_idx[i]]  <= fq.enq_instr[32*i +: 32];
               pc_mem[wr_idx[i]]     <= fq.enq_pc + PC_W'(4 * i);
               taken_mem[wr_idx[i]]  <= fq.enq_predtaken[i];
               target_mem[wr_idx[i]] <= fq.enq_predtarget[32*i +: 32];
            end
         end
      end
   end

   // Pointer and occupancy state. A redirect wins over everything and
   // empties the queue; otherwise enqueue and dequeue are applied together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (fq.redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + n_deq[PTR_W-1:0];
         tail  <= tail + n_enq[PTR_W-1:0];
         count <= count + n_enq - n_deq;
      end
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FETCH_W, default 4: instruction slots per fetch packet.
REQ-002 SHALL have parameter DEQ_W, default 2: maximum instructions dequeued per cycle, DEQ_W <= FETCH_W.
REQ-003 SHALL have parameter DEPTH, default 16: entries; power of two, DEPTH >= 2*FETCH_W.
REQ-004 SHALL have parameter PC_W, default 64: PC width.
REQ-005 SHALL have port clock, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port enq_valid, input, 1: fetch packet present.
REQ-008 SHALL have port enq_ready, output, 1: room for a full packet.
REQ-009 SHALL have port enq_pc, input, PC_W: PC of slot 0.
REQ-010 SHALL have port enq_instr, input, 32*FETCH_W: slot i at bits [32i+31:32i].
REQ-011 SHALL have port enq_mask, input, FETCH_W: per-slot valid.
REQ-012 SHALL have port enq_predtaken, input, FETCH_W: per-slot predicted-taken.
REQ-013 SHALL have port enq_predtarget, input, 32*FETCH_W: per-slot predicted target.
REQ-014 SHALL have port redirect_valid, input, 1: flush request.
REQ-015 SHALL have port backend_stall, input, 1: blocks dequeue.
REQ-016 SHALL have port deq_ready, input, 1: consumer accepts all presented lanes.
REQ-017 SHALL have port deq_valid, output, DEQ_W: per-lane valid, lane 0 oldest.
REQ-018 SHALL have ports deq_instr (32*DEQ_W), deq_pc (PC_W*DEQ_W), deq_predtaken (DEQ_W) and deq_predtarget (32*DEQ_W), all outputs: per-lane entry fields.
REQ-019 SHALL have ports count, output, log2(DEPTH)+1: occupied entries; and empty, output, 1: count==0.

Function
REQ-020 SHALL drive enq_ready = (DEPTH - count >= FETCH_W), using the registered count only; same-cycle dequeue SHALL NOT be credited.
REQ-021 SHALL accept a packet when enq_valid && enq_ready && !redirect_valid.
REQ-022 SHALL keep a slot only if its enq_mask bit is set and no lower-index slot is both masked valid and predicted taken; slots after the first predicted-taken slot SHALL be dropped.
REQ-023 SHALL write kept slots contiguously at the tail in ascending slot order, with entry pc = enq_pc + 4*i modulo 2^PC_W, where i is the original slot index.
REQ-024 SHALL accept an all-zero enq_mask packet as a handshake that adds no entries.
REQ-025 SHALL drive deq_valid[k] = (count > k) && !backend_stall && !redirect_valid, with lane k presenting entry head+k; outputs are combinational from storage.
REQ-026 SHALL, when deq_ready && !backend_stall && !redirect_valid, remove min(count, DEQ_W) entries from the head.
REQ-027 SHALL make an accepted entry visible on deq outputs in the cycle after acceptance (1-cycle latency).
REQ-028 SHALL update count_next = count + n_enq - n_deq on simultaneous enqueue and dequeue.
REQ-029 SHALL index head and tail modulo DEPTH, and both multi-entry writes and multi-entry reads SHALL wrap seamlessly.
REQ-030 SHALL, on redirect_valid, set head=tail=count=0 next cycle, discard the same-cycle packet and dequeue nothing that cycle.
REQ-031 SHALL leave entry storage contents unreset; only pointers and count are reset.

Reset
REQ-032 SHALL, while reset_n=0 (asynchronous, mid-operation included), set head=0, tail=0, count=0, empty=1, deq_valid=0 and enq_ready=1.
REQ-033 SHALL accept enqueue in the first cycle after reset_n rises.

Verification
REQ-034 SHALL cover: reset; enq_pc=0x1000, mask=1111, predtaken=0 -> next cycle count=4, deq_valid=11, deq_pc lanes 0x1000/0x1004.
REQ-035 SHALL cover: mask=1011, predtaken=0010, enq_pc=0x2000 -> exactly 2 entries with pcs 0x2000 and 0x2004; slot 3 dropped.
REQ-036 SHALL cover: fill to count=13 -> enq_ready=0; then one dequeue of 2 -> count=11, enq_ready=1 the following cycle.
REQ-037 SHALL cover: head=14, enqueue 4 then drain with deq_ready=1 -> order preserved across wrap, pcs ascending by 4.
REQ-038 SHALL cover: count=6, redirect_valid with enq_valid and deq_ready high -> deq_valid=00 that cycle, count=0 and empty=1 next cycle, packet discarded.
REQ-039 SHALL cover: backend_stall=1 with count=3 and deq_ready=1 -> deq_valid=00, count unchanged; release -> 2 entries removed.
